ex_muldiv: RTL and testbench

//  Iterative HI/LO multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/ex_muldiv_if.sv | 35 +++
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit: op encodings,
// FSM state type and two's-complement helpers.
package mips_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic [DEF_DATA_W-1:0] mdNeg(input logic [DEF_DATA_W-1:0] v);
    return ~v + DEF_DATA_W'(1);
  endfunction

  function automatic logic [2*DEF_DATA_W-1:0] mdNegWide(input logic [2*DEF_DATA_W-1:0] v);
    return ~v + (2*DEF_DATA_W)'(1);
  endfunction

  // Magnitude for signed ops; 0x80000000 stays 0x80000000 and is read as unsigned.
  function automatic logic [DEF_DATA_W-1:0] mdAbs(input logic [DEF_DATA_W-1:0] v,
                                                  input logic isSigned);
    return (isSigned && v[DEF_DATA_W-1]) ? mdNeg(v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Port bundle between the EX stage (master) and the HI/LO multiply/divide unit (slave).
interface ex_muldiv_if #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W
);
  import mips_pkg::*;

  // start is a single-cycle launch pulse accepted only while busy is low; busy rises
  // on the next edge and stays high until the result is in HI/LO, and done pulses
  // for one cycle with busy low once HI/LO hold the result. cancel drops an op in
  // flight without touching HI/LO; mthi/mtlo write wdata on the next edge.
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              cancel;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  logic              done;
  md_state_t         dbgState;

  modport master (
    output start, op, src_a, src_b, cancel, mthi, mtlo, wdata,
    input  hi_out, lo_out, busy, done, dbgState
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, mthi, mtlo, wdata,
    output hi_out, lo_out, busy, done, dbgState
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one result bit per cycle.
// Build option MULDIV_EARLY_EXIT_EN: multiply leaves CALC once the remaining multiplier is zero.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  md_state_t           state;
  md_state_t           stateNext;
  logic [CNT_W-1:0]    count;
  logic [1:0]          opReg;
  logic                negQuot;
  logic                negRem;
  logic [DATA_W-1:0]   dividendRaw;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   hiReg;
  logic [DATA_W-1:0]   loReg;
  logic                busyReg;
  logic                doneReg;

  logic                launchSigned;
  logic [DATA_W-1:0]   absA;
  logic [DATA_W-1:0]   absB;
  logic                isDiv;
  logic                lastStep;
  logic [2*DATA_W-1:0] mulAcc;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W-1:0] divAcc;
  logic [2*DATA_W-1:0] product;
  logic                divZero;
  logic [DATA_W-1:0]   resHi;
  logic [DATA_W-1:0]   resLo;

  assign launchSigned = ~bus.op[0];
  assign absA         = mdAbs(bus.src_a, launchSigned);
  assign absB         = mdAbs(bus.src_b, launchSigned);
  assign isDiv        = opReg[1];

`ifdef MULDIV_EARLY_EXIT_EN
  assign lastStep = isDiv ? (count == LAST_CNT) : ((mplier >> 1) == '0);
`else
  assign lastStep = (count == LAST_CNT);
`endif

  // acc is shared: product accumulator for multiply, {remainder, quotient} for divide.
  always_comb begin
    mulAcc = acc + (mplier[0] ? mcand : '0);
    trial  = acc[2*DATA_W-1:DATA_W-1] - {1'b0, mplier};
    divAcc = trial[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                           : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  end

  always_comb begin
    product = negQuot ? mdNegWide(acc) : acc;
    divZero = (mplier == '0);
    resHi   = product[2*DATA_W-1:DATA_W];
    resLo   = product[DATA_W-1:0];
    if (isDiv) begin
      if (divZero) begin
        resHi = dividendRaw;
        resLo = '1;
      end else begin
        resHi = negRem  ? mdNeg(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
        resLo = negQuot ? mdNeg(acc[DATA_W-1:0])        : acc[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (bus.start && !bus.cancel) stateNext = CALC;
      CALC: begin
        if (bus.cancel)    stateNext = IDLE;
        else if (lastStep) stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      opReg       <= MD_MULT;
      negQuot     <= 1'b0;
      negRem      <= 1'b0;
      dividendRaw <= '0;
      mplier      <= '0;
      acc         <= '0;
      mcand       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            count       <= '0;
            opReg       <= bus.op;
            negQuot     <= launchSigned && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            negRem      <= launchSigned && bus.src_a[DATA_W-1];
            dividendRaw <= bus.src_a;
            mplier      <= absB;
            mcand       <= {{DATA_W{1'b0}}, absA};
            acc         <= bus.op[1] ? {{DATA_W{1'b0}}, absA} : '0;
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            count <= count + 1'b1;
            if (isDiv) begin
              acc <= divAcc;
            end else begin
              acc    <= mulAcc;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A completing op wins over an MTHI/MTLO in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      busyReg <= (stateNext != IDLE);
      doneReg <= (state == FIX) && !bus.cancel;
      if ((state == FIX) && !bus.cancel) begin
        hiReg <= resHi;
        loReg <= resLo;
      end else begin
        if (bus.mthi) hiReg <= bus.wdata;
        if (bus.mtlo) loReg <= bus.wdata;
      end
    end
  end

  assign bus.hi_out   = hiReg;
  assign bus.lo_out   = loReg;
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.dbgState = state;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: arithmetic reference model plus per-cycle compare, directed and random ops.
module tb_ex_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_W(W)) bus ();
  ex_muldiv #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void modelResult(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] u;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = 32'h0;
    lo = 32'h0;
    case (op)
      MD_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin u = {32'h0, a} * {32'h0, b}; hi = u[63:32]; lo = u[31:0]; end
      default: begin
        if (b == 32'h0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == MD_DIV) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endfunction

  function automatic int modelLatency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [31:0] m;
    int k;
    if (!op[1]) begin
      m = (op == MD_MULT && b[31]) ? (~b + 32'd1) : b;
      k = 0;
      while (m != 32'h0) begin m = m >> 1; k++; end
      if (k == 0) k = 1;
      return k + 1;
    end
`endif
    return W + 1;
  endfunction

  logic [2*W-1:0] exp_q[$];
  logic [31:0] mHi = 32'h0, mLo = 32'h0;
  int          mLeft = 0;
  logic        mDone = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic [31:0] h, l;
    if (!rst) begin
      mHi = 32'h0; mLo = 32'h0; mLeft = 0; mDone = 1'b0;
      exp_q.delete();
    end else begin
      mDone = 1'b0;
      if (bus.mthi) mHi = bus.wdata;
      if (bus.mtlo) mLo = bus.wdata;
      if (mLeft > 0) begin
        if (bus.cancel) begin
          mLeft = 0;
          void'(exp_q.pop_front());
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            {mHi, mLo} = exp_q.pop_front();
            mDone = 1'b1;
          end
        end
      end else if (bus.start && !bus.cancel) begin
        modelResult(bus.op, bus.src_a, bus.src_b, h, l);
        exp_q.push_back({h, l});
        mLeft = modelLatency(bus.op, bus.src_b);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmpEn && rst) begin
      check("cyc_busy", bus.busy, mLeft > 0);
      check("cyc_done", bus.done, mDone);
      check("cyc_hi", bus.hi_out, mHi);
      check("cyc_lo", bus.lo_out, mLo);
      check("cyc_idle_state", bus.dbgState == IDLE, mLeft == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic driveNoise();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      bus.mthi  = 1'($urandom_range(0, 1));
      bus.mtlo  = 1'($urandom_range(0, 1));
      bus.wdata = $urandom;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noisy, output int busyN, output int doneN);
    int guard;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    if (noisy) driveNoise();
    @(negedge clk);
    bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
    busyN = 0; doneN = 0; guard = 0;
    forever begin
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.cancel = 1'b0;
      if (bus.busy) busyN++;
      if (bus.done) doneN++;
      if (!bus.busy) break;
      if (guard >= 100) begin
        checks++; failures++;
        $display("FAIL op_timeout busy still high after %0d cycles, required low", guard);
        break;
      end
      guard++;
      if (noisy) begin
        driveNoise();
        if ($urandom_range(0, 99) == 0) bus.cancel = 1'b1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (bus.done) doneN++;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hiReq,
                          input logic [31:0] loReq, input int busyReq);
    int bn, dn;
    logic [31:0] mh, ml;
    modelResult(op, a, b, mh, ml);
    check({name, "_model_hi"}, mh, hiReq);
    check({name, "_model_lo"}, ml, loReq);
    runOp(op, a, b, 1'b0, bn, dn);
    check({name, "_hi"}, bus.hi_out, hiReq);
    check({name, "_lo"}, bus.lo_out, loReq);
    check({name, "_busy_cycles"}, bn, busyReq);
    check({name, "_done_pulses"}, dn, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bn, dn, busyLong, dSeen;
    logic [1:0] rop;
    bus.start = 1'b0; bus.op = MD_MULT; bus.src_a = '0; bus.src_b = '0;
    bus.cancel = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;

    #12;
    check("rst_hi", bus.hi_out, 32'h0);
    check("rst_lo", bus.lo_out, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cmpEn = 1'b1;

`ifdef MULDIV_EARLY_EXIT_EN
    busyLong = 3;
`else
    busyLong = 33;
`endif
    directed("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, busyLong);
    directed("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
             modelLatency(MD_MULTU, 32'hFFFF_FFFF));
    directed("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    directed("divu_by0", MD_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 33);
    directed("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
`ifdef MULDIV_EARLY_EXIT_EN
    directed("ee_5x3", MD_MULTU, 32'd5, 32'd3, 32'h0, 32'd15, 3);
    directed("ee_x0", MD_MULTU, 32'hDEAD_BEEF, 32'd0, 32'h0, 32'h0, 2);
`endif

    // Cancel mid-CALC: HI keeps the MTHI value, no done.
    @(negedge clk); bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
    @(negedge clk); bus.mthi = 1'b0;
    bus.start = 1'b1; bus.op = MD_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk); bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 1'b0);
    check("cancel_hi", bus.hi_out, 32'h1234_5678);
    dSeen = 0;
    repeat (4) begin
      if (bus.done) dSeen++;
      @(negedge clk);
    end
    check("cancel_no_done", dSeen, 0);

    // start together with cancel in IDLE is dropped.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(negedge clk); bus.start = 1'b0; bus.cancel = 1'b0;
    check("start_cancel_idle_busy", bus.busy, 1'b0);

    // Random ops with MTHI/MTLO traffic, idle gaps and occasional cancels.
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      runOp(rop, pickOperand(), pickOperand(), 1'b1, bn, dn);
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.cancel = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        driveNoise();
        bus.cancel = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.cancel = 1'b0;
    end

    // Reset in the middle of CALC clears everything at once.
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, bn, dn);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULT; bus.src_a = 32'h0000_0123; bus.src_b = 32'h0000_0456;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_hi", bus.hi_out, 32'h0);
    check("midrst_lo", bus.lo_out, 32'h0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_timeout simulation time exceeded, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
